multicycle_control_unit: RTL

FSM-based control unit for the multicycle RV32I core. It replaces the single-cycle combinational Control_Unit and is placed between the instruction register and the shared-memory datapath. It sequences each instruction through fetch, decode, execute, memory and writeback states. Memory access states are stretched by a parametrised latency counter, and it adds LUI and illegal-opcode handling.

---
 rtl/multicycle_control_unit.sv | 238 +++++++++++++++++++++++
 1 files changed

// File: rtl/multicycle_control_unit.sv
// ============================================================================
// multicycle_control_unit: FSM sequencer for the multicycle RV32I core.
// Optional macro MCCU_BRANCH_EXT_EN adds bne/blt/bge.       Revision: 1.0
// ============================================================================
`default_nettype none

module multicycle_control_unit #(
  parameter int MEM_LAT = 1,
  parameter int CNT_W   = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] op,
  input  logic [2:0] funct3,
  input  logic       funct7,
  input  logic       Zero,
  input  logic       Neg,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [2:0] ALUControl,
  output logic [2:0] ImmSrc,
  output logic       RegWrite,
  output logic       IllegalInstr,
  output logic [3:0] state_o
);

  localparam logic [3:0] c_fetch    = 4'd0;
  localparam logic [3:0] c_decode   = 4'd1;
  localparam logic [3:0] c_memadr   = 4'd2;
  localparam logic [3:0] c_memread  = 4'd3;
  localparam logic [3:0] c_memwb    = 4'd4;
  localparam logic [3:0] c_memwrite = 4'd5;
  localparam logic [3:0] c_executer = 4'd6;
  localparam logic [3:0] c_executei = 4'd7;
  localparam logic [3:0] c_aluwb    = 4'd8;
  localparam logic [3:0] c_branch   = 4'd9;
  localparam logic [3:0] c_jal      = 4'd10;
  localparam logic [3:0] c_lui      = 4'd11;

  localparam logic [6:0] c_op_load  = 7'b0000011;
  localparam logic [6:0] c_op_store = 7'b0100011;
  localparam logic [6:0] c_op_r     = 7'b0110011;
  localparam logic [6:0] c_op_i     = 7'b0010011;
  localparam logic [6:0] c_op_br    = 7'b1100011;
  localparam logic [6:0] c_op_jal   = 7'b1101111;
  localparam logic [6:0] c_op_lui   = 7'b0110111;

  localparam logic [CNT_W-1:0] c_last_cnt = CNT_W'(MEM_LAT - 1);

  logic [3:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             w_last;
  logic             w_mem_state;
  logic             w_op_legal;
  logic             w_take;
  logic             w_br_bad;
  logic             w_pc_update;
  logic             w_branch;
  logic             w_illegal;
  logic [1:0]       w_alu_op;

  assign w_last      = (cnt_q == c_last_cnt);
  assign w_mem_state = (state_q == c_fetch) || (state_q == c_memread) ||
                       (state_q == c_memwrite);
  assign state_o     = state_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= c_fetch;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      c_fetch:    if (w_last) state_d = c_decode;
      c_decode: begin
        case (op)
          c_op_load, c_op_store: state_d = c_memadr;
          c_op_r:                state_d = c_executer;
          c_op_i:                state_d = c_executei;
          c_op_br:               state_d = c_branch;
          c_op_jal:              state_d = c_jal;
          c_op_lui:              state_d = c_lui;
          default:               state_d = c_fetch;
        endcase
      end
      c_memadr:   state_d = op[5] ? c_memwrite : c_memread;
      c_memread:  if (w_last) state_d = c_memwb;
      c_memwrite: if (w_last) state_d = c_fetch;
      c_executer, c_executei, c_jal, c_lui: state_d = c_aluwb;
      default:    state_d = c_fetch;
    endcase
  end

  // Counter restarts on any state change so each stretched state starts at 0.
  always_comb begin
    cnt_d = '0;
    if ((state_d == state_q) && w_mem_state) cnt_d = cnt_q + CNT_W'(1);
  end

  always_comb begin
    ImmSrc     = 3'b000;
    w_op_legal = 1'b1;
    case (op)
      c_op_load, c_op_i, c_op_r: ImmSrc = 3'b000;
      c_op_store:                ImmSrc = 3'b001;
      c_op_br:                   ImmSrc = 3'b010;
      c_op_jal:                  ImmSrc = 3'b011;
      c_op_lui:                  ImmSrc = 3'b100;
      default:                   w_op_legal = 1'b0;
    endcase
  end

`ifdef MCCU_BRANCH_EXT_EN
  always_comb begin
    w_take   = 1'b0;
    w_br_bad = 1'b0;
    case (funct3)
      3'b000:  w_take = Zero;
      3'b001:  w_take = ~Zero;
      3'b100:  w_take = Neg;
      3'b101:  w_take = ~Neg;
      default: w_br_bad = 1'b1;
    endcase
  end
`else
  logic w_unused_neg;
  assign w_take       = Zero;
  assign w_br_bad     = 1'b0;
  assign w_unused_neg = Neg;
`endif

  always_comb begin
    AdrSrc      = 1'b0;
    ResultSrc   = 2'b00;
    ALUSrcA     = 2'b00;
    ALUSrcB     = 2'b00;
    w_alu_op    = 2'b00;
    IRWrite     = 1'b0;
    MemWrite    = 1'b0;
    RegWrite    = 1'b0;
    w_pc_update = 1'b0;
    w_branch    = 1'b0;
    w_illegal   = 1'b0;
    case (state_q)
      c_fetch: begin
        ALUSrcB     = 2'b10;
        ResultSrc   = 2'b10;
        IRWrite     = w_last;
        w_pc_update = w_last;
      end
      c_decode: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b01;
        w_illegal = ~w_op_legal;
      end
      c_memadr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      c_memread:  AdrSrc = 1'b1;
      c_memwb: begin
        ResultSrc = 2'b01;
        RegWrite  = 1'b1;
      end
      c_memwrite: begin
        AdrSrc   = 1'b1;
        MemWrite = 1'b1;
      end
      c_executer: begin
        ALUSrcA  = 2'b10;
        w_alu_op = 2'b10;
      end
      c_executei: begin
        ALUSrcA  = 2'b10;
        ALUSrcB  = 2'b01;
        w_alu_op = 2'b10;
      end
      c_aluwb:    RegWrite = 1'b1;
      c_branch: begin
        ALUSrcA   = 2'b10;
        w_alu_op  = 2'b01;
        w_branch  = 1'b1;
        w_illegal = w_br_bad;
      end
      c_jal: begin
        ALUSrcA     = 2'b01;
        ALUSrcB     = 2'b10;
        w_pc_update = 1'b1;
      end
      c_lui: begin
        ALUSrcA = 2'b11;
        ALUSrcB = 2'b01;
      end
      default: ;
    endcase
    PCWrite      = w_pc_update | (w_branch & w_take);
    IllegalInstr = w_illegal;
    // Strobes are masked during reset; selects already sit at FETCH values.
    if (rst) begin
      PCWrite      = 1'b0;
      IRWrite      = 1'b0;
      RegWrite     = 1'b0;
      MemWrite     = 1'b0;
      IllegalInstr = 1'b0;
    end
  end

  always_comb begin
    ALUControl = 3'b000;
    case (w_alu_op)
      2'b01: ALUControl = 3'b001;
      2'b10: begin
        case (funct3)
          3'b000:  ALUControl = (op[5] & funct7) ? 3'b001 : 3'b000;
          3'b010:  ALUControl = 3'b101;
          3'b110:  ALUControl = 3'b011;
          3'b111:  ALUControl = 3'b010;
          default: ALUControl = 3'b000;
        endcase
      end
      default: ALUControl = 3'b000;
    endcase
  end

endmodule

`default_nettype wire
